// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
// Bundles the pipeline-side request/response signals and the memory-side
// bus of mem_access_unit into one interface.
//   pipeline -> unit : req_valid, req_write, req_size, req_signed, req_addr, req_wdata
//   unit -> pipeline : busy, resp_valid, resp_rdata, resp_err
//   unit -> memory   : mem_write_enabled, mem_addr, mem_w_data
//   memory -> unit   : mem_r_data, mem_status (00 idle, 01 busy, 10 done)
// Modports: slave is the unit's view, master is the pipeline/memory view.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        mem_write_enabled;
  logic [31:0] mem_addr;
  logic [31:0] mem_w_data;
  logic [31:0] mem_r_data;
  logic [1:0]  mem_status;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  mem_r_data, mem_status,
    output busy, resp_valid, resp_rdata, resp_err,
    output mem_write_enabled, mem_addr, mem_w_data
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output mem_r_data, mem_status,
    input  busy, resp_valid, resp_rdata, resp_err,
    input  mem_write_enabled, mem_addr, mem_w_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Turns a single pipeline load/store request into a handshake with a
// memory that reports its progress through mem_status. Each memory phase
// first waits for the memory to be idle (SYNC) and then for it to report
// done (ACCESS); the result is signalled with a one-cycle resp_valid pulse.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high reset
//   bus_io : mem_access_unit_if.slave (pipeline request/response + memory bus)
// Configuration:
//   MEM_ACCESS_SUBWORD_EN : when defined, byte/half loads are lane-extracted
//   and sign/zero-extended, and byte/half stores become read-modify-write.
//   When undefined every access is a word access and req_size/req_signed
//   are ignored.
module mem_access_unit (
  input  logic             clk,
  input  logic             reset,
  mem_access_unit_if.slave bus_io
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        writePhase_q, writePhase_d;

  logic        accept;
  logic        misaligned;
  logic        memIsIdle;
  logic        memIsDone;
  logic [31:0] loadValue;

  assign accept    = (state_q == IDLE) && bus_io.req_valid;
  assign memIsIdle = (bus_io.mem_status == 2'b00);
  assign memIsDone = (bus_io.mem_status == 2'b10);

`ifdef MEM_ACCESS_SUBWORD_EN
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic        write_q, write_d;
  logic        rmwRead;
  logic [31:0] mergedWord;

  // Moves the addressed lane down to bit 0 and extends it to 32 bits.
  function automatic logic [31:0] extractLoad(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size,
                                              input logic        sgn);
    logic [31:0] shifted;
    shifted = word >> {lane, 3'b000};
    if (size == 2'b00)      return {{24{sgn & shifted[7]}}, shifted[7:0]};
    else if (size == 2'b01) return {{16{sgn & shifted[15]}}, shifted[15:0]};
    else                    return word;
  endfunction

  // Replaces the addressed byte/half of the sampled word with store data.
  function automatic logic [31:0] mergeStore(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  lane,
                                             input logic [1:0]  size);
    logic [31:0] mask;
    mask = (size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
    return (word & ~(mask << {lane, 3'b000})) | ((wdata & mask) << {lane, 3'b000});
  endfunction

  // Size 11 is handled like a word; bytes can never be misaligned.
  assign misaligned = bus_io.req_size[1] ? (bus_io.req_addr[1:0] != 2'b00)
                                         : (bus_io.req_size[0] & bus_io.req_addr[0]);
  // A sub-word store starts with a read phase whose data gets merged.
  assign rmwRead    = write_q & ~writePhase_q & ~size_q[1];
  assign loadValue  = extractLoad(bus_io.mem_r_data, addr_q[1:0], size_q, sgn_q);
  assign mergedWord = mergeStore(bus_io.mem_r_data, wdata_q, addr_q[1:0], size_q);
`else
  logic unusedCfg;
  assign misaligned = (bus_io.req_addr[1:0] != 2'b00);
  assign loadValue  = bus_io.mem_r_data;
  assign unusedCfg  = ^{bus_io.req_size, bus_io.req_signed, addr_q[1:0]};
`endif

  // State and datapath registers; reset returns everything to zero/IDLE,
  // which also drops mem_write_enabled of an in-flight write phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      writePhase_q <= 1'b0;
`ifdef MEM_ACCESS_SUBWORD_EN
      size_q       <= 2'b00;
      sgn_q        <= 1'b0;
      write_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      writePhase_q <= writePhase_d;
`ifdef MEM_ACCESS_SUBWORD_EN
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      write_q      <= write_d;
`endif
    end
  end

  // Next-state logic. mem_status 11 matches neither idle nor done, so it
  // simply holds SYNC/ACCESS.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (bus_io.req_valid) state_d = misaligned ? DONE : SYNC;
      SYNC:   if (memIsIdle) state_d = ACCESS;
      ACCESS: begin
        if (memIsDone) begin
`ifdef MEM_ACCESS_SUBWORD_EN
          state_d = rmwRead ? SYNC : DONE;
`else
          state_d = DONE;
`endif
        end
      end
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates: capture the request on acceptance, then consume the
  // memory read data when a read phase completes (load result or merge).
  always_comb begin
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    writePhase_d = writePhase_q;
`ifdef MEM_ACCESS_SUBWORD_EN
    size_d       = size_q;
    sgn_d        = sgn_q;
    write_d      = write_q;
`endif
    if (accept) begin
      addr_d  = bus_io.req_addr;
      wdata_d = bus_io.req_wdata;
      err_d   = misaligned;
`ifdef MEM_ACCESS_SUBWORD_EN
      size_d       = bus_io.req_size;
      sgn_d        = bus_io.req_signed;
      write_d      = bus_io.req_write;
      writePhase_d = bus_io.req_write & ~misaligned & bus_io.req_size[1];
`else
      writePhase_d = bus_io.req_write & ~misaligned;
`endif
    end else if ((state_q == ACCESS) && memIsDone && !writePhase_q) begin
`ifdef MEM_ACCESS_SUBWORD_EN
      if (rmwRead) begin
        wdata_d      = mergedWord;
        writePhase_d = 1'b1;
      end else begin
        rdata_d = loadValue;
      end
`else
      rdata_d = loadValue;
`endif
    end
  end

  // Outputs are decoded from the current state and registers only.
  always_comb begin
    bus_io.busy              = (state_q != IDLE);
    bus_io.resp_valid        = (state_q == DONE);
    bus_io.resp_err          = (state_q == DONE) & err_q;
    bus_io.resp_rdata        = rdata_q;
    bus_io.mem_write_enabled = ((state_q == SYNC) || (state_q == ACCESS)) & writePhase_q;
    bus_io.mem_addr          = {addr_q[31:2], 2'b00};
    bus_io.mem_w_data        = wdata_q;
  end

endmodule
